// File: rtl/wb_pkg.sv
// wb_pkg -- shared types and defaults for the writeback arbiter.
//
// Contents:
//   entry_t               buffered result {regdest[4:0], wbvalue[31:0]}
//   DEPTH_DEFAULT         default result-buffer depth (power of two, >= 4)
//   STALL_THRESH_DEFAULT  default occupancy at which issue is held
//   PTR_W                 buffer pointer width for the default depth
//   is_valid()            a result is a real write only if writereg=1 and regdest!=r0

package wb_pkg;

    localparam int DEPTH_DEFAULT        = 8;
    localparam int STALL_THRESH_DEFAULT = 3;
    localparam int PTR_W                = $clog2(DEPTH_DEFAULT);

    typedef struct packed {
        logic [4:0]  regdest;
        logic [31:0] wbvalue;
    } entry_t;

    function automatic logic is_valid(input logic writereg, input logic [4:0] regdest);
        return writereg && (regdest != 5'd0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- circular result buffer with two enqueue ports and one dequeue port.
//
// Port a is the older of the two enqueues; when both are offered in one cycle
// a lands before b. A dequeue in the same cycle frees its slot for the
// enqueues, so a full buffer can still accept one new entry while draining.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   enq_a, enq_a_data  older enqueue request and payload
//   enq_b, enq_b_data  younger enqueue request and payload
//   deq                remove the head entry (caller guarantees count != 0)
//   head               oldest entry
//   count              occupancy, 0..DEPTH
//   entries            all slots in age order, entries[0] = oldest; only the
//                      first count are meaningful
//   drop               an offered enqueue found no free slot this cycle

module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enq_a,
    input  entry_t                   enq_a_data,
    input  logic                     enq_b,
    input  entry_t                   enq_b_data,
    input  logic                     deq,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output entry_t [DEPTH-1:0]       entries,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count_q;
    logic [CW-1:0]    free;
    logic             take_a;
    logic             take_b;
    logic [AW-1:0]    b_ptr;

    // Slots available this cycle include the one being vacated by deq.
    always_comb begin
        free   = CW'(DEPTH) - CW'(count_q) + CW'(deq);
        take_a = enq_a && (free != '0);
        take_b = enq_b && (free > CW'(take_a));
        drop   = (enq_a && !take_a) || (enq_b && !take_b);
        b_ptr  = wr_ptr + AW'(take_a);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr + AW'(deq);
            wr_ptr  <= wr_ptr + AW'(take_a) + AW'(take_b);
            count_q <= count_q + (AW+1)'(take_a) + (AW+1)'(take_b) - (AW+1)'(deq);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which slots hold live data, so clearing the payload would be wasted logic.
    always_ff @(posedge clock) begin
        if (take_a) mem[wr_ptr] <= enq_a_data;
        if (take_b) mem[b_ptr]  <= enq_b_data;
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

    // Pointers are AW bits wide and DEPTH is a power of two, so the sum wraps.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rd_ptr + AW'(i)];
        end
    end

endmodule

// File: rtl/writeback_arb.sv
// writeback_arb -- merges the ALU/shift (X) and memory (M) pipe results onto a
// single register-file write port, buffering whichever result loses.
//
// Commit priority each cycle: buffer head, then M, then X. Any valid input not
// committed is buffered the same cycle (M ahead of X), which keeps per-register
// write order equal to arrival order. The write port is registered.
//
// Optional feature: define WB_BYPASS_EN to compile in the operand bypass
// lookup; without it the wb_is_fwd_* outputs are tied to 0.
//
// Ports:
//   clock, reset                      rising-edge clock, async active-low reset
//   x_wb_regdest/writereg/wbvalue     X pipe result
//   m_wb_regdest/writereg/wbvalue     M pipe result
//   is_wb_rs, is_wb_rt                issue source registers for bypass
//   wb_rf_writereg/regdest/wbvalue    registered register-file write port
//   wb_is_stall                       hold issue (buffer occupancy >= STALL_THRESH)
//   wb_is_fwd_a_valid/value           bypass for rs
//   wb_is_fwd_b_valid/value           bypass for rt
//   wb_ovf                            sticky buffer-overflow flag

module writeback_arb
    import wb_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int STALL_THRESH = STALL_THRESH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  x_wb_regdest,
    input  logic        x_wb_writereg,
    input  logic [31:0] x_wb_wbvalue,
    input  logic [4:0]  m_wb_regdest,
    input  logic        m_wb_writereg,
    input  logic [31:0] m_wb_wbvalue,
    input  logic [4:0]  is_wb_rs,
    input  logic [4:0]  is_wb_rt,
    output logic        wb_rf_writereg,
    output logic [4:0]  wb_rf_regdest,
    output logic [31:0] wb_rf_wbvalue,
    output logic        wb_is_stall,
    output logic        wb_is_fwd_a_valid,
    output logic [31:0] wb_is_fwd_a_value,
    output logic        wb_is_fwd_b_valid,
    output logic [31:0] wb_is_fwd_b_value,
    output logic        wb_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic              x_ok;
    logic              m_ok;
    entry_t            x_entry;
    entry_t            m_entry;
    entry_t            head;
    entry_t            commit;
    logic              commit_valid;
    logic              enq_a;
    logic              enq_b;
    entry_t            enq_a_data;
    entry_t            enq_b_data;
    logic              deq;
    logic [AW:0]       count;
    entry_t [DEPTH-1:0] entries;
    logic              drop;

    assign x_ok    = is_valid(x_wb_writereg, x_wb_regdest);
    assign m_ok    = is_valid(m_wb_writereg, m_wb_regdest);
    assign x_entry = '{regdest: x_wb_regdest, wbvalue: x_wb_wbvalue};
    assign m_entry = '{regdest: m_wb_regdest, wbvalue: m_wb_wbvalue};

    // NOTE: every output of this block gets a default first so no path through
    // the if/else chain leaves a variable unassigned and infers a latch.
    always_comb begin
        commit_valid = 1'b0;
        commit       = '0;
        deq          = 1'b0;
        enq_a        = 1'b0;
        enq_b        = 1'b0;
        enq_a_data   = m_entry;
        enq_b_data   = x_entry;
        if (count != '0) begin
            // Oldest result first; both inputs queue behind it, M ahead of X.
            commit_valid = 1'b1;
            commit       = head;
            deq          = 1'b1;
            enq_a        = m_ok;
            enq_b        = x_ok;
        end else if (m_ok) begin
            commit_valid = 1'b1;
            commit       = m_entry;
            enq_a        = x_ok;
            enq_a_data   = x_entry;
        end else if (x_ok) begin
            commit_valid = 1'b1;
            commit       = x_entry;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .enq_a      (enq_a),
        .enq_a_data (enq_a_data),
        .enq_b      (enq_b),
        .enq_b_data (enq_b_data),
        .deq        (deq),
        .head       (head),
        .count      (count),
        .entries    (entries),
        .drop       (drop)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs from the same pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_rf_writereg <= 1'b0;
            wb_rf_regdest  <= '0;
            wb_rf_wbvalue  <= '0;
            wb_ovf         <= 1'b0;
        end else begin
            wb_rf_writereg <= commit_valid;
            wb_rf_regdest  <= commit.regdest;
            wb_rf_wbvalue  <= commit.wbvalue;
            wb_ovf         <= wb_ovf | drop;
        end
    end

    assign wb_is_stall = (int'(count) >= STALL_THRESH);

`ifdef WB_BYPASS_EN
    // Walk sources from oldest to newest so the last match wins:
    // committed register, buffer oldest..newest, M input, X input.
    function automatic logic [32:0] lookup(input logic [4:0] src);
        logic [32:0] r;
        r = '0;
        if (wb_rf_writereg && wb_rf_regdest == src) r = {1'b1, wb_rf_wbvalue};
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) && entries[i].regdest == src) r = {1'b1, entries[i].wbvalue};
        end
        if (m_ok && m_wb_regdest == src) r = {1'b1, m_wb_wbvalue};
        if (x_ok && x_wb_regdest == src) r = {1'b1, x_wb_wbvalue};
        if (src == 5'd0) r = '0;
        return r;
    endfunction

    always_comb begin
        {wb_is_fwd_a_valid, wb_is_fwd_a_value} = lookup(is_wb_rs);
        {wb_is_fwd_b_valid, wb_is_fwd_b_value} = lookup(is_wb_rt);
    end
`else
    logic unused_bypass;
    assign unused_bypass     = ^{is_wb_rs, is_wb_rt, entries};
    assign wb_is_fwd_a_valid = 1'b0;
    assign wb_is_fwd_a_value = '0;
    assign wb_is_fwd_b_valid = 1'b0;
    assign wb_is_fwd_b_value = '0;
`endif

endmodule

// File: tb/tb_writeback_arb.sv
// tb_writeback_arb -- directed vector table plus hand-written multi-cycle
// sequences (stall threshold, overflow, reset) for writeback_arb.

module tb_writeback_arb;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  x_wb_regdest, m_wb_regdest, is_wb_rs, is_wb_rt;
    logic        x_wb_writereg, m_wb_writereg;
    logic [31:0] x_wb_wbvalue, m_wb_wbvalue;
    logic        wb_rf_writereg, wb_is_stall, wb_ovf;
    logic [4:0]  wb_rf_regdest;
    logic [31:0] wb_rf_wbvalue;
    logic        wb_is_fwd_a_valid, wb_is_fwd_b_valid;
    logic [31:0] wb_is_fwd_a_value, wb_is_fwd_b_value;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    writeback_arb #(.DEPTH(8), .STALL_THRESH(3)) dut (
        .clock             (clock),
        .reset             (reset),
        .x_wb_regdest      (x_wb_regdest),
        .x_wb_writereg     (x_wb_writereg),
        .x_wb_wbvalue      (x_wb_wbvalue),
        .m_wb_regdest      (m_wb_regdest),
        .m_wb_writereg     (m_wb_writereg),
        .m_wb_wbvalue      (m_wb_wbvalue),
        .is_wb_rs          (is_wb_rs),
        .is_wb_rt          (is_wb_rt),
        .wb_rf_writereg    (wb_rf_writereg),
        .wb_rf_regdest     (wb_rf_regdest),
        .wb_rf_wbvalue     (wb_rf_wbvalue),
        .wb_is_stall       (wb_is_stall),
        .wb_is_fwd_a_valid (wb_is_fwd_a_valid),
        .wb_is_fwd_a_value (wb_is_fwd_a_value),
        .wb_is_fwd_b_valid (wb_is_fwd_b_valid),
        .wb_is_fwd_b_value (wb_is_fwd_b_value),
        .wb_ovf            (wb_ovf)
    );

    typedef struct {
        logic        xw;
        logic [4:0]  xr;
        logic [31:0] xv;
        logic        mw;
        logic [4:0]  mr;
        logic [31:0] mv;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [32:0] fa;
        logic [32:0] fb;
        logic [37:0] rf;
        logic        stall;
        logic        ovf;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mkv(input logic xw, input logic [4:0] xr, input logic [31:0] xv,
                                 input logic mw, input logic [4:0] mr, input logic [31:0] mv,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [32:0] fa, input logic [32:0] fb,
                                 input logic [37:0] rf, input logic stall, input logic ovf);
        vec_t v;
        v.xw = xw; v.xr = xr; v.xv = xv;
        v.mw = mw; v.mr = mr; v.mv = mv;
        v.rs = rs; v.rt = rt; v.fa = fa; v.fb = fb;
        v.rf = rf; v.stall = stall; v.ovf = ovf;
        return v;
    endfunction

    // Encoding used by the sequences: M result k -> r(k), 0x1000+k;
    // X result k -> r(16+k), 0x2000+k.
    function automatic logic [37:0] rfm(input int k);
        return {1'b1, 5'(k), 32'(32'h1000 + k)};
    endfunction

    function automatic logic [37:0] rfx(input int k);
        return {1'b1, 5'(16 + k), 32'(32'h2000 + k)};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic xw, input logic [4:0] xr, input logic [31:0] xv,
                         input logic mw, input logic [4:0] mr, input logic [31:0] mv,
                         input logic [4:0] rs, input logic [4:0] rt);
        x_wb_writereg = xw; x_wb_regdest = xr; x_wb_wbvalue = xv;
        m_wb_writereg = mw; m_wb_regdest = mr; m_wb_wbvalue = mv;
        is_wb_rs = rs; is_wb_rt = rt;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    task automatic drive_mx(input int mk, input int xk);
        drive(1'b1, 5'(16 + xk), 32'(32'h2000 + xk), 1'b1, 5'(mk), 32'(32'h1000 + mk), 5'd0, 5'd0);
    endtask

    function automatic logic [79:0] regs_now();
        return {wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_is_stall, wb_ovf};
    endfunction

    function automatic logic [79:0] regs_exp(input logic [37:0] rf, input logic stall, input logic ovf);
        return {rf, stall, ovf};
    endfunction

    initial begin
        int          mk_list [3];
        logic [37:0] fill_exp [3];
        logic [37:0] drain_exp [3];
        logic [37:0] e;

        // Directed vectors: {inputs, bypass this cycle, write port after edge}.
        vecs[0] = mkv(0, 0, 0,            0, 0, 0,     0, 0, 33'd0,              33'd0,
                      38'd0, 0, 0);
        vecs[1] = mkv(1, 5, 32'h1234,     0, 0, 0,     5, 7, {1'b1, 32'h1234},   33'd0,
                      {1'b1, 5'd5, 32'h1234}, 0, 0);
        vecs[2] = mkv(0, 0, 0,            0, 0, 0,     5, 0, {1'b1, 32'h1234},   33'd0,
                      38'd0, 0, 0);
        vecs[3] = mkv(1, 0, 32'hDEAD,     0, 0, 0,     0, 0, 33'd0,              33'd0,
                      38'd0, 0, 0);
        vecs[4] = mkv(1, 3, 32'hB,        1, 3, 32'hA, 3, 5, {1'b1, 32'hB},      33'd0,
                      {1'b1, 5'd3, 32'hA}, 0, 0);
        vecs[5] = mkv(0, 0, 0,            0, 0, 0,     3, 4, {1'b1, 32'hB},      33'd0,
                      {1'b1, 5'd3, 32'hB}, 0, 0);
        vecs[6] = mkv(1, 9, 32'h99,       0, 7, 32'h77, 7, 9, 33'd0,             {1'b1, 32'h99},
                      {1'b1, 5'd9, 32'h99}, 0, 0);
        vecs[7] = mkv(0, 0, 0,            1, 10, 32'h10, 9, 3, {1'b1, 32'h99},   33'd0,
                      {1'b1, 5'd10, 32'h10}, 0, 0);

        reset = 1'b0;
        drive_idle();
        #1;
        check("reset state", regs_now(), 80'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].xw, vecs[i].xr, vecs[i].xv, vecs[i].mw, vecs[i].mr, vecs[i].mv,
                  vecs[i].rs, vecs[i].rt);
            #1;
            check($sformatf("vec%0d bypass", i),
                  {wb_is_fwd_a_valid, wb_is_fwd_a_value, wb_is_fwd_b_valid, wb_is_fwd_b_value},
                  BYP ? {vecs[i].fa, vecs[i].fb} : 80'd0);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d commit", i), regs_now(),
                  regs_exp(vecs[i].rf, vecs[i].stall, vecs[i].ovf));
        end

        // Stall threshold: three dual-arrival cycles, then drain.
        mk_list   = '{11, 12, 13};
        fill_exp  = '{rfm(11), rfx(4), rfm(12)};
        drain_exp = '{rfx(5), rfm(13), rfx(6)};
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive_mx(mk_list[c], 4 + c);
            @(posedge clock);
            #1;
            check($sformatf("stall fill %0d", c), regs_now(), regs_exp(fill_exp[c], c == 2, 1'b0));
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive_idle();
            @(posedge clock);
            #1;
            check($sformatf("stall drain %0d", c), regs_now(), regs_exp(drain_exp[c], 1'b0, 1'b0));
        end
        @(negedge clock);
        @(posedge clock);
        #1;
        check("stall empty", regs_now(), 80'd0);

        // Overflow: dual arrivals until the buffer is full; the ninth cycle drops X9.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            drive_mx(k, k);
            @(posedge clock);
            #1;
            if (k == 1) e = rfm(1);
            else if ((k - 2) % 2 == 0) e = rfx(1 + (k - 2) / 2);
            else e = rfm((k + 1) / 2);
            check($sformatf("ovf fill %0d", k), regs_now(), regs_exp(e, k >= 3, k == 9));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            drive_idle();
            @(posedge clock);
            #1;
            e = (i % 2 == 0) ? rfx(5 + i / 2) : rfm(5 + (i + 1) / 2);
            check($sformatf("ovf drain %0d", i), regs_now(), regs_exp(e, (7 - i) >= 3, 1'b1));
        end
        @(negedge clock);
        @(posedge clock);
        #1;
        check("ovf empty", regs_now(), regs_exp(38'd0, 1'b0, 1'b1));

        // Reset with four entries buffered.
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            drive_mx(1 + c, 1 + c);
        end
        @(posedge clock);
        #1;
        check("pre-reset", {wb_is_stall, wb_ovf}, {1'b1, 1'b1});
        @(negedge clock);
        drive_idle();
        #2;
        reset = 1'b0;
        #1;
        check("async reset", regs_now(), 80'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(posedge clock);
        #1;
        check("first after release", regs_now(), regs_exp({1'b1, 5'd4, 32'h44}, 1'b0, 1'b0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            drive_idle();
            @(posedge clock);
            #1;
            check($sformatf("no stale %0d", c), regs_now(), 80'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
